// File: rtl/control_multi.sv
// Multicycle MIPS control unit: registered state sequencer with a memory-ready
// handshake, bounded wait timeout and a sticky trap on illegal opcode or bus timeout.
module control_multi #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int WAIT_LIMIT    = 15,
  parameter int WAIT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_BNE    = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);
  localparam bit TIMEOUT_EN = (WAIT_LIMIT != 0);

  state_t            state_q, state_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;

  logic rdy;
  logic memState;

  assign rdy      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign memState = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  // Next-state logic. The wait counter only survives while a memory state is
  // stalled; every other path (including re-entry of a memory state) clears it.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    wait_d   = '0;
    trap_d   = trap_q;
    cause_d  = cause_q;

    if (memState && !rdy) begin
      if (TIMEOUT_EN && (wait_q == LIMIT)) begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
        cause_d = CAUSE_TIMEOUT;
      end else if (wait_q == LIMIT) begin
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      unique case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          opcode_d = opcode;
          case (opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BEQ;
            OP_BNE:       state_d = S_BNE;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDIEX;
            default: begin
              state_d = S_TRAP;
              trap_d  = 1'b1;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_d = S_MEMWB;
        S_MEMWR:  state_d = S_FETCH;
        S_MEMWB:  state_d = S_FETCH;
        S_EXEC:   state_d = S_RWB;
        S_RWB:    state_d = S_FETCH;
        S_BEQ:    state_d = S_FETCH;
        S_BNE:    state_d = S_FETCH;
        S_JUMP:   state_d = S_FETCH;
        S_ADDIEX: state_d = S_ADDIWB;
        S_ADDIWB: state_d = S_FETCH;
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      wait_q   <= '0;
      trap_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      wait_q   <= wait_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  // Datapath controls are a pure decode of the current state; only FETCH
  // qualifies its instruction/PC load with the handshake.
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = rdy;
        PCWrite = rdy;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
      end
      S_BNE: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        PCWriteCondNe = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench for control_multi: stimulus queues hand-computed per-cycle
// expectations, a monitor on the falling edge pops and compares them.
module tb_control_multi;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state;

  control_multi #(
    .MEM_HANDSHAKE(1),
    .WAIT_LIMIT   (3),
    .WAIT_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .PCWriteCondNe(PCWriteCondNe),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .IRWrite      (IRWrite),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .PCSource     (PCSource),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: PCWrite PCWriteCond PCWriteCondNe IorD MemRead MemWrite MemtoReg
  //            IRWrite RegDst RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2]
  localparam logic [16:0] C_FETCH_RDY  = 17'b1_0_0_0_1_0_0_1_0_0_0_01_00_00;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_DECODE     = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] C_MEMADR     = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [16:0] C_MEMRD      = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MEMWR      = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MEMWB      = 17'b0_0_0_0_0_0_1_0_0_1_0_00_00_00;
  localparam logic [16:0] C_EXEC       = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [16:0] C_RWB        = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [16:0] C_BEQ        = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] C_BNE        = 17'b0_0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] C_JUMP       = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [16:0] C_ADDIWB     = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [16:0] C_ZERO       = 17'b0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        trp;
    logic [1:0]  cause;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  logic [16:0] ctrlNow;
  assign ctrlNow = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
                    MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Drive one cycle of inputs and record what the DUT must show during it.
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy,
                               input logic [3:0] st, input logic [16:0] ctrl,
                               input logic trp, input logic [1:0] cause, input string name);
    exp_t e;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    e.st = st; e.ctrl = ctrl; e.trp = trp; e.cause = cause; e.name = name;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, ".state"}, 32'(state), 32'(e.st));
        checkOutput({e.name, ".ctrl"}, 32'(ctrlNow), 32'(e.ctrl));
        checkOutput({e.name, ".trap"}, 32'(trap), 32'(e.trp));
        checkOutput({e.name, ".cause"}, 32'(trap_cause), 32'(e.cause));
      end
    end
  end

  initial begin
    reset = 1'b1;
    opcode = 6'd0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset release, then R-type
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "rst_fetch");
    applyStimulus(0, 6'd0, 1, 4'd1, C_DECODE, 0, 2'b00, "r_decode");
    applyStimulus(0, 6'd0, 1, 4'd6, C_EXEC, 0, 2'b00, "r_exec");
    applyStimulus(0, 6'd0, 1, 4'd7, C_RWB, 0, 2'b00, "r_rwb");

    // LW with two wait states; opcode input changes after DECODE to prove latching
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "lw_fetch");
    applyStimulus(0, 6'd35, 1, 4'd1, C_DECODE, 0, 2'b00, "lw_decode");
    applyStimulus(0, 6'd43, 1, 4'd2, C_MEMADR, 0, 2'b00, "lw_memadr");
    applyStimulus(0, 6'd43, 0, 4'd3, C_MEMRD, 0, 2'b00, "lw_memrd_w1");
    applyStimulus(0, 6'd43, 0, 4'd3, C_MEMRD, 0, 2'b00, "lw_memrd_w2");
    applyStimulus(0, 6'd43, 1, 4'd3, C_MEMRD, 0, 2'b00, "lw_memrd_ok");
    applyStimulus(0, 6'd43, 1, 4'd4, C_MEMWB, 0, 2'b00, "lw_memwb");

    // SW
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "sw_fetch");
    applyStimulus(0, 6'd43, 1, 4'd1, C_DECODE, 0, 2'b00, "sw_decode");
    applyStimulus(0, 6'd35, 1, 4'd2, C_MEMADR, 0, 2'b00, "sw_memadr");
    applyStimulus(0, 6'd35, 1, 4'd5, C_MEMWR, 0, 2'b00, "sw_memwr");

    // BNE, BEQ, J, ADDI
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "bne_fetch");
    applyStimulus(0, 6'd5, 1, 4'd1, C_DECODE, 0, 2'b00, "bne_decode");
    applyStimulus(0, 6'd5, 1, 4'd12, C_BNE, 0, 2'b00, "bne_exec");
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "beq_fetch");
    applyStimulus(0, 6'd4, 1, 4'd1, C_DECODE, 0, 2'b00, "beq_decode");
    applyStimulus(0, 6'd4, 1, 4'd8, C_BEQ, 0, 2'b00, "beq_exec");
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "j_fetch");
    applyStimulus(0, 6'd2, 1, 4'd1, C_DECODE, 0, 2'b00, "j_decode");
    applyStimulus(0, 6'd2, 1, 4'd9, C_JUMP, 0, 2'b00, "j_exec");
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "addi_fetch");
    applyStimulus(0, 6'd8, 1, 4'd1, C_DECODE, 0, 2'b00, "addi_decode");
    applyStimulus(0, 6'd8, 1, 4'd10, C_MEMADR, 0, 2'b00, "addi_ex");
    applyStimulus(0, 6'd8, 1, 4'd11, C_ADDIWB, 0, 2'b00, "addi_wb");

    // Ready arrives on the 4th FETCH cycle, exactly at the limit: no trap
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 6'd0, 0, 4'd0, C_FETCH_WAIT, 0, 2'b00, "edge_fetch_wait");
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "edge_fetch_ok");
    applyStimulus(0, 6'd0, 1, 4'd1, C_DECODE, 0, 2'b00, "edge_decode");
    applyStimulus(0, 6'd0, 1, 4'd6, C_EXEC, 0, 2'b00, "edge_exec");
    applyStimulus(0, 6'd0, 1, 4'd7, C_RWB, 0, 2'b00, "edge_rwb");

    // Reset asserted while MEMWR is stalled
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "rsw_fetch");
    applyStimulus(0, 6'd43, 1, 4'd1, C_DECODE, 0, 2'b00, "rsw_decode");
    applyStimulus(0, 6'd43, 1, 4'd2, C_MEMADR, 0, 2'b00, "rsw_memadr");
    applyStimulus(0, 6'd43, 0, 4'd5, C_MEMWR, 0, 2'b00, "rsw_memwr_w");
    applyStimulus(1, 6'd43, 0, 4'd5, C_MEMWR, 0, 2'b00, "rsw_memwr_rst");
    applyStimulus(0, 6'd0, 1, 4'd0, C_FETCH_RDY, 0, 2'b00, "rsw_fetch_after");

    // Illegal opcode: sticky trap for 20 cycles, then a reset pulse
    applyStimulus(0, 6'd63, 1, 4'd1, C_DECODE, 0, 2'b00, "ill_decode");
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 6'd0, i[0], 4'd13, C_ZERO, 1, 2'b01, "ill_trap");
    applyStimulus(1, 6'd0, 1, 4'd13, C_ZERO, 1, 2'b01, "ill_trap_rst");
    applyStimulus(0, 6'd0, 0, 4'd0, C_FETCH_WAIT, 0, 2'b00, "ill_fetch_after");

    // mem_ready stuck low in FETCH: 3 more low cycles, then timeout trap
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 6'd0, 0, 4'd0, C_FETCH_WAIT, 0, 2'b00, "to_fetch_wait");
    applyStimulus(0, 6'd0, 1, 4'd13, C_ZERO, 1, 2'b10, "to_trap");
    applyStimulus(0, 6'd0, 1, 4'd13, C_ZERO, 1, 2'b10, "to_trap_hold");

    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_multi.md
Name: control_multi

Overview:
- Multicycle MIPS control unit (COD3e Sec. 5.5 style, extended); successor to the single-cycle decoder.
- Registered state machine sequences the fetch, decode, execute, memory and writeback steps.
- Drives the multicycle datapath muxes and enables.
- Supports R-format, LW, SW, BEQ, BNE, J and ADDI.
- Adds a parametrised memory-ready handshake with a wait timeout, and a sticky trap on illegal opcode or bus timeout.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- WAIT_LIMIT, 15: maximum consecutive mem_ready-low cycles tolerated in one memory state; 0 disables the timeout.
- WAIT_W, 4: wait counter width; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; sampled only in DECODE.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  PC write if ALU Zero (BEQ).
- PCWriteCondNe  output  1  PC write if not ALU Zero (BNE).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemtoReg  output  1  register write data select: 1 = MDR.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  destination select: 1 = rd, 0 = rt.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- ALUOp  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
- PCSource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump address.
- trap  output  1  sticky error flag.
- trap_cause  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- state  output  4  current state code, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11, BNE=12, TRAP=13.
  - Codes 14-15 go to FETCH on the next clock, with all control outputs 0.
- Control outputs are decoded combinationally from state (and mem_ready where stated). Any output not listed for a state is 0; no x values are ever driven.
- Reset (synchronous, any state, including mid-wait or in TRAP):
  - state=FETCH, wait counter=0, trap=0, trap_cause=00.
  - Outputs then take the FETCH decode.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = rdy, where rdy = mem_ready (or 1 if MEM_HANDSHAKE=0).
  - Goes to DECODE when rdy; otherwise stays.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0 -> EXEC
  - 35 and 43 -> MEMADR
  - 4 -> BEQ
  - 5 -> BNE
  - 2 -> JUMP
  - 8 -> ADDIEX
  - anything else -> TRAP, cause 01
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if the latched opcode is 35, else MEMWR. The opcode is latched in DECODE.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB when rdy.
- MEMWR: MemWrite=1, IorD=1. Goes to FETCH when rdy.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegDst=1, RegWrite=1. Next FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Next FETCH.
- BNE: same as BEQ, but PCWriteCondNe=1 and PCWriteCond=0. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- Wait counter (memory states FETCH, MEMRD, MEMWR):
  - Cleared on every transition into a memory state.
  - Increments each cycle rdy=0, saturating at WAIT_LIMIT.
  - If rdy=0 and counter==WAIT_LIMIT (with WAIT_LIMIT != 0): next state TRAP, cause 10.
  - rdy=1 on the same cycle the limit is reached wins; the access completes normally.
- TRAP:
  - All control outputs 0, trap=1; trap and trap_cause registered on entry.
  - Leaves only on reset.
- Instruction latency with zero wait states:
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE and J: 3 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> state=0, MemRead=1, IRWrite=1, PCWrite=1, trap=0 on the first cycle.
- R-type (opcode 0), mem_ready=1 -> states 0,1,6,7,0; RWB shows RegDst=1, RegWrite=1; EXEC shows ALUOp=10.
- LW (opcode 35) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; IorD=1 throughout MEMRD; MEMWB shows MemtoReg=1.
- BNE (opcode 5) -> states 0,1,12,0; PCWriteCondNe=1, PCWriteCond=0, ALUOp=01, PCSource=01. Repeat for BEQ (opcode 4) -> PCWriteCond=1.
- Illegal opcode 63 -> DECODE then TRAP; trap=1, trap_cause=01, all controls 0 for 20 cycles; a reset pulse returns to FETCH with trap=0.
- MEM_HANDSHAKE=1, WAIT_LIMIT=3, mem_ready stuck low in FETCH -> TRAP with cause 10 after 4 low cycles. Repeat with mem_ready rising on the 4th cycle -> no trap, DECODE next. Reset asserted mid-MEMWR -> FETCH next cycle, no MemWrite.
